// File: rtl/fc_ctrl_pkg.sv
// Shared types and width helpers for the fully-connected layer controller.
package fc_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMP,
        DRAIN,
        OUT
    } fc_state_t;

    // Never returns zero, so a single-value counter still has one bit.
    function automatic int fc_cnt_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    function automatic int fc_axw(input int m);
        return fc_cnt_w(m);
    endfunction

    function automatic int fc_aww(input int m, input int n);
        return fc_cnt_w(m * n);
    endfunction

endpackage

// File: rtl/fc_ctrl_cnt.sv
// Modulo-K counter with enable, synchronous clear and a last flag.
module fc_ctrl_cnt
    import fc_ctrl_pkg::*;
#(
    parameter  int K = 2,
    localparam int W = fc_cnt_w(K)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == W'(K - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fc_ctrl_5_2.sv
// Control FSM for one fully-connected layer: loads M inputs,
// runs N rows of M MACs each and hands every row result downstream.
module fc_ctrl_5_2
    import fc_ctrl_pkg::*;
#(
    parameter  int M   = 5,
    parameter  int N   = 2,
    localparam int AXW = fc_axw(M),
    localparam int AWW = fc_aww(M, N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           input_valid,
    output logic           input_ready,
    output logic           wr_en_x,
    output logic [AXW-1:0] addr_x,
    output logic [AWW-1:0] addr_w,
    output logic           clear_acc,
    output logic           en_acc,
    output logic           output_valid,
    input  logic           output_ready
);

    localparam int NW = fc_cnt_w(N);

    fc_state_t      state;
    fc_state_t      state_nx;
    logic [AXW-1:0] idx;
    logic [AXW-1:0] m;
    logic [AXW-1:0] m_off;
    logic [NW-1:0]  n;
    logic           idx_last;
    logic           m_last;
    logic           n_last;
    logic           n_final;
    logic           load_hs;
    logic           load_done;
    logic           out_hs;
    logic           in_comp;
    logic [AWW-1:0] row_base;

    // Reset gates the write strobe so nothing is written while held in reset.
    assign load_hs   = input_valid && input_ready && reset;
    assign wr_en_x   = load_hs;
    assign load_done = load_hs && idx_last;
    assign out_hs    = output_valid && output_ready;
    assign n_final   = (n == NW'(N - 1));

    assign addr_x = (state == LOAD) ? idx : m_off;
    assign addr_w = row_base + AWW'(m_off);

    fc_ctrl_cnt #(.K(M)) u_idx (
        .clk   (clk),
        .rst_n (reset),
        .en    (load_hs),
        .clr   (1'b0),
        .cnt   (idx),
        .last  (idx_last)
    );

    fc_ctrl_cnt #(.K(M)) u_m (
        .clk   (clk),
        .rst_n (reset),
        .en    (in_comp),
        .clr   (1'b0),
        .cnt   (m),
        .last  (m_last)
    );

    fc_ctrl_cnt #(.K(N)) u_n (
        .clk   (clk),
        .rst_n (reset),
        .en    (out_hs),
        .clr   (load_done),
        .cnt   (n),
        .last  (n_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // DRAIN/OUT keep pointing at the last element of the row just read.
    always_comb begin
        state_nx     = state;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        in_comp      = 1'b0;
        m_off        = '0;
        unique case (state)
            LOAD: begin
                input_ready = 1'b1;
                if (load_done) state_nx = COMP;
            end
            COMP: begin
                in_comp = 1'b1;
                m_off   = m;
                if (m_last) state_nx = DRAIN;
            end
            DRAIN: begin
                m_off    = AXW'(M - 1);
                state_nx = OUT;
            end
            OUT: begin
                output_valid = 1'b1;
                m_off        = AXW'(M - 1);
                if (out_hs) state_nx = n_final ? LOAD : COMP;
            end
            default: state_nx = LOAD;
        endcase
    end

    // Accumulator controls trail the address by the one-cycle read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_acc    <= 1'b0;
            clear_acc <= 1'b0;
            row_base  <= '0;
        end else begin
            en_acc    <= in_comp;
            clear_acc <= in_comp && (m == '0);
            if (load_done) begin
                row_base <= '0;
            end else if (out_hs) begin
                row_base <= n_last ? '0 : row_base + AWW'(M);
            end
        end
    end

endmodule

// File: tb/tb_fc_ctrl_5_2.sv
// Directed bench for fc_ctrl_5_2: vector table plus hand-written sequences.
module tb_fc_ctrl_5_2;

    localparam int M = 5;
    localparam int N = 2;

    typedef struct packed {
        logic       iv;
        logic       orr;
        logic       rdy;
        logic       wr;
        logic [2:0] ax;
        logic [3:0] aw;
        logic       clr;
        logic       en;
        logic       ov;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       input_valid = 1'b0;
    logic       output_ready = 1'b0;
    logic       input_ready;
    logic       wr_en_x;
    logic [2:0] addr_x;
    logic [3:0] addr_w;
    logic       clear_acc;
    logic       en_acc;
    logic       output_valid;

    int   checks = 0;
    int   fails  = 0;
    vec_t tbl [20];

    always #5 clk = ~clk;

    fc_ctrl_5_2 #(.M(M), .N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .wr_en_x      (wr_en_x),
        .addr_x       (addr_x),
        .addr_w       (addr_w),
        .clear_acc    (clear_acc),
        .en_acc       (en_acc),
        .output_valid (output_valid),
        .output_ready (output_ready)
    );

    function automatic vec_t mk(
        input logic iv, input logic orr, input logic rdy, input logic wr,
        input logic [2:0] ax, input logic [3:0] aw,
        input logic clr, input logic en, input logic ov);
        vec_t v;
        v.iv = iv; v.orr = orr; v.rdy = rdy; v.wr = wr;
        v.ax = ax; v.aw = aw; v.clr = clr; v.en = en; v.ov = ov;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic rdy,
                             input logic wr, input logic [2:0] ax,
                             input logic [3:0] aw, input logic clr,
                             input logic en, input logic ov);
        check({tag, ".input_ready"}, input_ready, rdy);
        check({tag, ".wr_en_x"}, wr_en_x, wr);
        check({tag, ".addr_x"}, addr_x, ax);
        check({tag, ".addr_w"}, addr_w, aw);
        check({tag, ".clear_acc"}, clear_acc, clr);
        check({tag, ".en_acc"}, en_acc, en);
        check({tag, ".output_valid"}, output_valid, ov);
    endtask

    // Entered just after a rising edge with the FSM in LOAD at index 0.
    task automatic run_table(input string tag);
        for (int i = 0; i < 20; i++) begin
            input_valid  = tbl[i].iv;
            output_ready = tbl[i].orr;
            @(negedge clk);
            check_all($sformatf("%s[%0d]", tag, i), tbl[i].rdy, tbl[i].wr,
                      tbl[i].ax, tbl[i].aw, tbl[i].clr, tbl[i].en,
                      tbl[i].ov);
            @(posedge clk);
            #1;
        end
    endtask

    // Returns at the falling edge of the first OUT cycle.
    task automatic wait_ov(input string tag, output int ens,
                           output int clrs);
        int k;
        ens  = 0;
        clrs = 0;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (output_valid) break;
            ens  += int'(en_acc);
            clrs += int'(clear_acc);
            @(posedge clk);
            #1;
        end
        check({tag, ".ov_timeout"}, (k < 30), 1);
    endtask

    initial begin
        int ens;
        int clrs;
        int hs;
        int exp_ax;

        tbl[0]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 1, 1, 2, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 1, 1, 3, 0, 0, 0, 0);
        tbl[4]  = mk(1, 1, 1, 1, 4, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 1, 0, 0, 1, 1, 1, 1, 0);
        tbl[7]  = mk(1, 1, 0, 0, 2, 2, 0, 1, 0);
        tbl[8]  = mk(1, 1, 0, 0, 3, 3, 0, 1, 0);
        tbl[9]  = mk(1, 1, 0, 0, 4, 4, 0, 1, 0);
        tbl[10] = mk(1, 1, 0, 0, 4, 4, 0, 1, 0);
        tbl[11] = mk(1, 1, 0, 0, 4, 4, 0, 0, 1);
        tbl[12] = mk(1, 1, 0, 0, 0, 5, 0, 0, 0);
        tbl[13] = mk(1, 1, 0, 0, 1, 6, 1, 1, 0);
        tbl[14] = mk(1, 1, 0, 0, 2, 7, 0, 1, 0);
        tbl[15] = mk(1, 1, 0, 0, 3, 8, 0, 1, 0);
        tbl[16] = mk(1, 1, 0, 0, 4, 9, 0, 1, 0);
        tbl[17] = mk(1, 1, 0, 0, 4, 9, 0, 1, 0);
        tbl[18] = mk(1, 1, 0, 0, 4, 9, 0, 0, 1);
        tbl[19] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Reset held for two clocks.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_table("vec1");

        // Output back-pressure: OUT must hold for 10 stalled cycles.
        input_valid  = 1'b1;
        output_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        input_valid = 1'b0;
        wait_ov("stall_r0", ens, clrs);
        check("stall_r0.en_count", ens, 5);
        check("stall_r0.clr_count", clrs, 1);
        for (int i = 0; i < 10; i++) begin
            check_all($sformatf("stall[%0d]", i), 0, 0, 4, 4, 0, 0, 1);
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        output_ready = 1'b1;
        @(posedge clk);
        #1;
        output_ready = 1'b0;
        wait_ov("stall_r1", ens, clrs);
        check("stall_r1.en_count", ens, 5);
        check("stall_r1.clr_count", clrs, 1);
        check("stall_r1.addr_w", addr_w, 9);
        check("stall_r1.addr_x", addr_x, 4);
        output_ready = 1'b1;
        @(posedge clk);
        #1;
        output_ready = 1'b0;
        @(negedge clk);
        check_all("stall_done", 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Gappy input stream: writes only on handshakes, exactly M of them.
        hs     = 0;
        exp_ax = 0;
        for (int c = 0; c < 200 && hs < M; c++) begin
            input_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rand.wr_en_x", wr_en_x, input_valid);
            check("rand.addr_x", addr_x, exp_ax);
            check("rand.input_ready", input_ready, 1);
            if (input_valid) begin
                hs++;
                exp_ax = (exp_ax + 1) % M;
            end
            @(posedge clk);
            #1;
        end
        check("rand.handshakes", hs, M);
        input_valid = 1'b1;
        @(negedge clk);
        check_all("rand_after", 0, 0, 0, 0, 0, 0, 0);

        // Reset during row 1 at m=2.
        input_valid  = 1'b0;
        output_ready = 1'b1;
        @(posedge clk);
        #1;
        wait_ov("mid_r0", ens, clrs);
        check("mid_r0.en_count", ens, 5);
        check("mid_r0.clr_count", clrs, 1);
        check("mid_r0.addr_w", addr_w, 4);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("mid.addr_x", addr_x, 2);
        check("mid.addr_w", addr_w, 7);
        check("mid.en_acc", en_acc, 1);
        input_valid = 1'b1;
        reset       = 1'b0;
        #1;
        check_all("mid_reset", 1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        run_table("vec2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/fc_ctrl_5_2.md
Name: fc_ctrl_5_2

Overview:
Control FSM that sequences one fully-connected layer datapath (input vector memory, weight ROM, MAC accumulator, ReLU output register) for M inputs and N outputs.
- Accepts M input words over a valid/ready handshake and generates the x-memory write strobes and addresses.
- Walks the weight ROM row by row and drives accumulator clear/enable.
- Presents each finished output over a valid/ready handshake.
- Carries no data; the datapath instance sits beside it inside the fc layer top.

Parameters:
M, 5, input vector length (MACs per output row); legal range 2 or more
N, 2, number of output rows per input vector; legal range 1 or more
AXW, $clog2(M), x-memory address width (derived, not overridable)
AWW, $clog2(M*N), weight ROM address width (derived, not overridable)

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
input_valid  in  1  upstream word available
input_ready  out  1  controller accepting an input word
wr_en_x  out  1  datapath writes input_data into x-memory at addr_x
addr_x  out  AXW  x-memory write/read address
addr_w  out  AWW  weight ROM read address
clear_acc  out  1  with en_acc: acc <= product (instead of acc + product)
en_acc  out  1  datapath accumulates the product of the current memory outputs
output_valid  out  1  datapath output register holds a finished row result
output_ready  in  1  downstream accepts the output

Behaviour:
- States: LOAD, COMP, DRAIN, OUT. Reset state: LOAD.
- Reset values (asynchronous): input_ready=1, wr_en_x=0, addr_x=0, addr_w=0, clear_acc=0, en_acc=0, output_valid=0; m and n counters 0.
- LOAD
  - input_ready=1.
  - wr_en_x = input_valid && input_ready (combinational), using the current addr_x.
  - On each handshake, addr_x increments.
  - On the handshake at addr_x=M-1: addr_x wraps to 0, n resets to 0, go to COMP.
  - input_valid low inserts gaps; no progress occurs.
- COMP (exactly M cycles)
  - input_ready=0; addr_x=m; addr_w=n*M+m; m increments each cycle.
  - At m=M-1: m wraps to 0 and the state goes to DRAIN.
- Memory read latency is 1 cycle, so en_acc and clear_acc are registered one cycle after the address.
  - en_acc=1 in COMP cycles 1..M-1 and in the DRAIN cycle.
  - clear_acc=1 only with the first en_acc of each row.
- DRAIN: 1 cycle, then OUT.
- OUT
  - output_valid=1; addresses held; en_acc=0.
  - If output_ready=0, hold indefinitely with all outputs stable.
  - On output_valid && output_ready with n<N-1: n increments, go to COMP.
  - On the handshake with n=N-1: go to LOAD; input_ready=1 next cycle.
- Latency: entering COMP at edge E gives output_valid=1 from edge E+M+1.
- Row throughput: M+2 cycles when output_ready is held high.
- No overlap of loading with compute: input_ready=0 from COMP entry until the final output handshake.
- Reset asserted mid-operation: all outputs go to reset values immediately and any partial vector is discarded. On release, the FSM resumes in LOAD with addr_x=0.
- Internal counters are sized from M and N. Weight address is formed as row base (n*M, kept as a running sum, no multiplier) plus m.

Decomposition:
- Package fc_ctrl_pkg holds:
  - state enum typedef (LOAD, COMP, DRAIN, OUT);
  - localparam functions for AXW and AWW.
- One natural sub-module: fc_ctrl_cnt, a modulo-K counter with enable, synchronous clear, asynchronous active-low reset and a last flag. Instantiate it for m (K=M), n (K=N) and the LOAD index.

Test Plan:
- Reset with clk running, reset=0 for 2 cycles -> input_ready=1, output_valid=0, all addresses 0, en_acc=0.
- M=5, N=2, input_valid held 1 -> wr_en_x for 5 cycles with addr_x 0,1,2,3,4, then input_ready=0.
  - addr_w 0..4 then 5..9.
  - en_acc 5 cycles per row; clear_acc only on the first of each.
  - output_valid at E+6.
- Output_ready held 1 -> row 0 accepted at E+7, row 1 output_valid at E+13, accepted at E+14, input_ready=1 after E+14.
- Output_ready low for 10 cycles during OUT -> output_valid stays 1; addr_w, addr_x stable; en_acc=0; no skipped rows.
- Random input_valid with 50% duty -> exactly 5 wr_en_x pulses, addr_x advances only on handshakes, no extra write after the 5th.
- Reset asserted during COMP at m=2, n=1 -> outputs return to reset values the same cycle. The next 5-word vector yields 2 correct outputs.
